// File: rtl/mips_pipeline_pkg.sv
// Shared definitions for the pipelined MIPS core: ID/EX bundle widths, control
// bundle layout and the Control unit decode used by the ID stage.
package mips_pipeline_pkg;

    localparam int DATA_W    = 32;
    localparam int RF_DEPTH  = 32;
    localparam int REG_IDX_W = 5;
    localparam int INSTR_W   = 32;
    localparam int CTRL_W    = 16;
    localparam int IMM_W     = 16;
    localparam int JUMP_W    = 26;
    localparam int SHAMT_W   = 5;
    localparam int FUNCT_W   = 6;
    localparam int OPCODE_W  = 6;

    localparam logic [INSTR_W-1:0]   NOP_INSTR = 32'h0;
    localparam logic [REG_IDX_W-1:0] REG_RA    = 5'd31;

    // Bit positions inside the 16-bit control bundle
    localparam int CTRL_REG_WRITE      = 0;
    localparam int CTRL_ALU_SRC        = 1;
    localparam int CTRL_ALUOP_LSB      = 2;
    localparam int CTRL_MEM_TO_REG_LSB = 6;
    localparam int CTRL_MEM_WRITE      = 8;
    localparam int CTRL_MEM_READ       = 9;
    localparam int CTRL_BNE            = 10;
    localparam int CTRL_BEQ            = 11;
    localparam int CTRL_JUMP_LSB       = 12;
    localparam int CTRL_REG_DST_LSB    = 14;

    typedef enum logic [1:0] {
        REG_DST_RT = 2'b00,
        REG_DST_RD = 2'b01,
        REG_DST_RA = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_IMM  = 2'b01,
        JUMP_REG  = 2'b10
    } jump_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_src_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_LUI   = 4'd6,
        ALU_FUNCT = 4'd7
    } aluop_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'h08;

    // Field order matches the ctrl_EX port, MSB first
    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] jump;
        logic       beq;
        logic       bne;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic [3:0] aluop;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    // The all-zero NOP decodes to an empty bundle so it is indistinguishable from a bubble
    function automatic ctrl_t control_unit(input logic [INSTR_W-1:0] instr);
        ctrl_t c;
        c = '0;
        if (instr != NOP_INSTR) begin
            case (instr[31:26])
                OP_RTYPE: begin
                    if (instr[5:0] == FUNCT_JR) begin
                        c.jump = JUMP_REG;
                    end else begin
                        c.reg_dst   = REG_DST_RD;
                        c.aluop     = ALU_FUNCT;
                        c.reg_write = 1'b1;
                    end
                end
                OP_J: c.jump = JUMP_IMM;
                OP_JAL: begin
                    c.jump       = JUMP_IMM;
                    c.reg_dst    = REG_DST_RA;
                    c.mem_to_reg = WB_PC4;
                    c.reg_write  = 1'b1;
                end
                OP_BEQ: begin
                    c.beq   = 1'b1;
                    c.aluop = ALU_SUB;
                end
                OP_BNE: begin
                    c.bne   = 1'b1;
                    c.aluop = ALU_SUB;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    c.alu_src   = 1'b1;
                    c.reg_write = 1'b1;
                    case (instr[31:26])
                        OP_SLTI: c.aluop = ALU_SLT;
                        OP_ANDI: c.aluop = ALU_AND;
                        OP_ORI:  c.aluop = ALU_OR;
                        OP_XORI: c.aluop = ALU_XOR;
                        OP_LUI:  c.aluop = ALU_LUI;
                        default: c.aluop = ALU_ADD;
                    endcase
                end
                OP_LW: begin
                    c.mem_read   = 1'b1;
                    c.mem_to_reg = WB_MEM;
                    c.alu_src    = 1'b1;
                    c.reg_write  = 1'b1;
                    c.aluop      = ALU_ADD;
                end
                OP_SW: begin
                    c.mem_write = 1'b1;
                    c.alu_src   = 1'b1;
                    c.aluop     = ALU_ADD;
                end
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/register_file_bypass.sv
// 32x32 register file with combinational reads, $0 hardwired to zero and a
// write-through bypass so a same-cycle WB write is visible to ID.
module register_file_bypass
    import mips_pipeline_pkg::*;
#(
    parameter int NBITS = DATA_W,
    parameter int NREGS = RF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] read_reg_1,
    input  logic [$clog2(NREGS)-1:0] read_reg_2,
    input  logic                     reg_write,
    input  logic [$clog2(NREGS)-1:0] write_reg,
    input  logic [NBITS-1:0]         write_data,
    output logic [NBITS-1:0]         read_data_1,
    output logic [NBITS-1:0]         read_data_2
);

    logic [NBITS-1:0] regs [NREGS];
    logic             write_en;

    assign write_en = reg_write && (write_reg != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    always_comb begin
        read_data_1 = regs[read_reg_1];
        if (read_reg_1 == '0) begin
            read_data_1 = '0;
        end else if (write_en && (write_reg == read_reg_1)) begin
            read_data_1 = write_data;
        end
    end

    always_comb begin
        read_data_2 = regs[read_reg_2];
        if (read_reg_2 == '0) begin
            read_data_2 = '0;
        end else if (write_en && (write_reg == read_reg_2)) begin
            read_data_2 = write_data;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, register file, decode, load-use
// hazard detection and the registered ID/EX bundle.
module id_stage
    import mips_pipeline_pkg::*;
#(
    parameter int NBITS = DATA_W,
    parameter int NREGS = RF_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instruction_IF,
    input  logic [NBITS-1:0]     pc_plus_4_IF,
    input  logic                 flush_M,
    input  logic                 reg_write_WB,
    input  logic [REG_IDX_W-1:0] write_reg_WB,
    input  logic [NBITS-1:0]     write_data_WB,
    output logic                 stall_IF,
    output logic [CTRL_W-1:0]    ctrl_EX,
    output logic [NBITS-1:0]     pc_plus_4_EX,
    output logic [NBITS-1:0]     read_data_1_EX,
    output logic [NBITS-1:0]     read_data_2_EX,
    output logic [NBITS-1:0]     immediate_EX,
    output logic [JUMP_W-1:0]    jump_field_EX,
    output logic [REG_IDX_W-1:0] rs_EX,
    output logic [REG_IDX_W-1:0] rt_EX,
    output logic [REG_IDX_W-1:0] rd_EX,
    output logic [SHAMT_W-1:0]   shamt_EX,
    output logic [FUNCT_W-1:0]   funct_EX
);

    logic [INSTR_W-1:0]   ifid_instr;
    logic [NBITS-1:0]     ifid_pc;
    logic [REG_IDX_W-1:0] ifid_rs;
    logic [REG_IDX_W-1:0] ifid_rt;
    logic [NBITS-1:0]     read_data_1_ID;
    logic [NBITS-1:0]     read_data_2_ID;
    logic [NBITS-1:0]     immediate_ID;
    ctrl_t                ctrl_ID;

    assign ifid_rs      = ifid_instr[25:21];
    assign ifid_rt      = ifid_instr[20:16];
    assign ctrl_ID      = control_unit(ifid_instr);
    assign immediate_ID = {{(NBITS-IMM_W){ifid_instr[15]}}, ifid_instr[15:0]};

    // Uses only registered state, so there is no combinational path from instruction_IF
    assign stall_IF = ctrl_EX[CTRL_MEM_READ] && (rt_EX != '0)
                   && ((rt_EX == ifid_rs) || (rt_EX == ifid_rt)) && !flush_M;

    register_file_bypass #(
        .NBITS (NBITS),
        .NREGS (NREGS)
    ) u_register_file (
        .clk         (clk),
        .reset       (reset),
        .read_reg_1  (ifid_rs),
        .read_reg_2  (ifid_rt),
        .reg_write   (reg_write_WB),
        .write_reg   (write_reg_WB),
        .write_data  (write_data_WB),
        .read_data_1 (read_data_1_ID),
        .read_data_2 (read_data_2_ID)
    );

    always_ff @(posedge clk) begin
        if (reset || flush_M) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
        end else if (!stall_IF) begin
            ifid_instr <= instruction_IF;
            ifid_pc    <= pc_plus_4_IF;
        end
    end

    // A stall injects an all-zero bubble; clearing mem_read is what ends the stall next cycle
    always_ff @(posedge clk) begin
        if (reset || flush_M || stall_IF) begin
            ctrl_EX        <= '0;
            pc_plus_4_EX   <= '0;
            read_data_1_EX <= '0;
            read_data_2_EX <= '0;
            immediate_EX   <= '0;
            jump_field_EX  <= '0;
            rs_EX          <= '0;
            rt_EX          <= '0;
            rd_EX          <= '0;
            shamt_EX       <= '0;
            funct_EX       <= '0;
        end else begin
            ctrl_EX        <= ctrl_ID;
            pc_plus_4_EX   <= ifid_pc;
            read_data_1_EX <= read_data_1_ID;
            read_data_2_EX <= read_data_2_ID;
            immediate_EX   <= immediate_ID;
            jump_field_EX  <= ifid_instr[25:0];
            rs_EX          <= ifid_rs;
            rt_EX          <= ifid_rt;
            rd_EX          <= ifid_instr[15:11];
            shamt_EX       <= ifid_instr[10:6];
            funct_EX       <= ifid_instr[5:0];
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a cycle-level reference model pushes the
// expected ID/EX bundle per cycle and a monitor pops and compares it.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_IF;
    logic [31:0] pc_plus_4_IF;
    logic        flush_M;
    logic        reg_write_WB;
    logic [4:0]  write_reg_WB;
    logic [31:0] write_data_WB;
    logic        stall_IF;
    logic [15:0] ctrl_EX;
    logic [31:0] pc_plus_4_EX;
    logic [31:0] read_data_1_EX;
    logic [31:0] read_data_2_EX;
    logic [31:0] immediate_EX;
    logic [25:0] jump_field_EX;
    logic [4:0]  rs_EX;
    logic [4:0]  rt_EX;
    logic [4:0]  rd_EX;
    logic [4:0]  shamt_EX;
    logic [5:0]  funct_EX;

    always #5 clk = ~clk;

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_IF (instruction_IF),
        .pc_plus_4_IF   (pc_plus_4_IF),
        .flush_M        (flush_M),
        .reg_write_WB   (reg_write_WB),
        .write_reg_WB   (write_reg_WB),
        .write_data_WB  (write_data_WB),
        .stall_IF       (stall_IF),
        .ctrl_EX        (ctrl_EX),
        .pc_plus_4_EX   (pc_plus_4_EX),
        .read_data_1_EX (read_data_1_EX),
        .read_data_2_EX (read_data_2_EX),
        .immediate_EX   (immediate_EX),
        .jump_field_EX  (jump_field_EX),
        .rs_EX          (rs_EX),
        .rt_EX          (rt_EX),
        .rd_EX          (rd_EX),
        .shamt_EX       (shamt_EX),
        .funct_EX       (funct_EX)
    );

    typedef struct {
        logic [15:0] ctrl;
        logic        stall;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [25:0] jf;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_ifid_instr;
    logic [31:0] m_ifid_pc;
    exp_t        m_ex;
    logic        m_ex_is_load;
    logic        last_stall;

    function automatic exp_t zero_exp();
        exp_t e;
        e.ctrl = '0; e.stall = 1'b0; e.pc = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
        e.jf = '0; e.rs = '0; e.rt = '0; e.rd = '0; e.shamt = '0; e.funct = '0;
        return e;
    endfunction

    // Control table written out as named fields, packed in the ctrl_EX port order
    function automatic logic [15:0] ref_ctrl(input logic [31:0] ins);
        logic [1:0] reg_dst, jump, m2r;
        logic       beq, bne, mr, mw, asrc, rw;
        logic [3:0] alu;
        reg_dst = 0; jump = 0; m2r = 0; beq = 0; bne = 0; mr = 0; mw = 0;
        asrc = 0; rw = 0; alu = 0;
        if (ins != 32'h0) begin
            case (ins[31:26])
                6'h00: if (ins[5:0] == 6'h08) jump = 2'b10;
                       else begin reg_dst = 2'b01; alu = 4'd7; rw = 1; end
                6'h02: jump = 2'b01;
                6'h03: begin jump = 2'b01; reg_dst = 2'b10; m2r = 2'b10; rw = 1; end
                6'h04: begin beq = 1; alu = 4'd1; end
                6'h05: begin bne = 1; alu = 4'd1; end
                6'h08, 6'h09: begin asrc = 1; rw = 1; alu = 4'd0; end
                6'h0A: begin asrc = 1; rw = 1; alu = 4'd5; end
                6'h0C: begin asrc = 1; rw = 1; alu = 4'd2; end
                6'h0D: begin asrc = 1; rw = 1; alu = 4'd3; end
                6'h0E: begin asrc = 1; rw = 1; alu = 4'd4; end
                6'h0F: begin asrc = 1; rw = 1; alu = 4'd6; end
                6'h23: begin mr = 1; m2r = 2'b01; asrc = 1; rw = 1; end
                6'h2B: begin mw = 1; asrc = 1; end
                default: ;
            endcase
        end
        return {reg_dst, jump, beq, bne, mr, mw, m2r, alu, asrc, rw};
    endfunction

    function automatic logic [31:0] reg_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (reg_write_WB && write_reg_WB == idx) return write_data_WB;
        return m_regs[idx];
    endfunction

    function automatic logic load_use(input exp_t ex, input logic is_load, input logic [31:0] ins);
        return is_load && (ex.rt != 0) && (ex.rt == ins[25:21] || ex.rt == ins[20:16]) && !flush_M;
    endfunction

    // Advance the reference model across one rising edge using the currently driven inputs
    task automatic model_step();
        logic stall_edge;
        exp_t nx;
        logic nx_load;
        int   simm;
        stall_edge = load_use(m_ex, m_ex_is_load, m_ifid_instr);
        nx = zero_exp();
        nx_load = 1'b0;
        if (!reset && !flush_M && !stall_edge) begin
            simm = int'(m_ifid_instr[15:0]);
            if (simm >= 32768) simm = simm - 65536;
            nx.ctrl  = ref_ctrl(m_ifid_instr);
            nx.pc    = m_ifid_pc;
            nx.rd1   = reg_read(m_ifid_instr[25:21]);
            nx.rd2   = reg_read(m_ifid_instr[20:16]);
            nx.imm   = simm;
            nx.jf    = m_ifid_instr[25:0];
            nx.rs    = m_ifid_instr[25:21];
            nx.rt    = m_ifid_instr[20:16];
            nx.rd    = m_ifid_instr[15:11];
            nx.shamt = m_ifid_instr[10:6];
            nx.funct = m_ifid_instr[5:0];
            nx_load  = (m_ifid_instr[31:26] == 6'h23);
        end
        if (reset || flush_M) begin
            m_ifid_instr = 32'h0;
            m_ifid_pc    = 32'h0;
        end else if (!stall_edge) begin
            m_ifid_instr = instruction_IF;
            m_ifid_pc    = pc_plus_4_IF;
        end
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else if (reg_write_WB && write_reg_WB != 0) begin
            m_regs[write_reg_WB] = write_data_WB;
        end
        m_ex = nx;
        m_ex_is_load = nx_load;
        nx.stall = load_use(m_ex, m_ex_is_load, m_ifid_instr);
        sb.push_back(nx);
        last_stall = stall_edge;
    endtask

    task automatic apply_stimulus(input logic rst, input logic [31:0] instr, input logic fl,
                                  input logic we, input logic [4:0] wr, input logic [31:0] wd);
        @(negedge clk);
        reset          = rst;
        instruction_IF = instr;
        pc_plus_4_IF   = $urandom() & 32'hFFFF_FFFC;
        flush_M        = fl;
        reg_write_WB   = we;
        write_reg_WB   = wr;
        write_data_WB  = wd;
        model_step();
    endtask

    task automatic apply_instr(input logic [31:0] instr);
        apply_stimulus(1'b0, instr, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_output(input exp_t e);
        check_field("ctrl_EX", 32'(ctrl_EX), 32'(e.ctrl));
        check_field("stall_IF", 32'(stall_IF), 32'(e.stall));
        check_field("pc_plus_4_EX", pc_plus_4_EX, e.pc);
        check_field("read_data_1_EX", read_data_1_EX, e.rd1);
        check_field("read_data_2_EX", read_data_2_EX, e.rd2);
        check_field("immediate_EX", immediate_EX, e.imm);
        check_field("jump_field_EX", 32'(jump_field_EX), 32'(e.jf));
        check_field("rs_EX", 32'(rs_EX), 32'(e.rs));
        check_field("rt_EX", 32'(rt_EX), 32'(e.rt));
        check_field("rd_EX", 32'(rd_EX), 32'(e.rd));
        check_field("shamt_EX", 32'(shamt_EX), 32'(e.shamt));
        check_field("funct_EX", 32'(funct_EX), 32'(e.funct));
    endtask

    // Monitor: one expected bundle per rising edge, sampled just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output(e);
            end
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] gen_instr();
        int          k;
        logic [4:0]  a, b, c;
        logic [15:0] imm;
        k   = $urandom_range(0, 12);
        a   = 5'($urandom_range(0, 7));
        b   = 5'($urandom_range(0, 7));
        c   = 5'($urandom_range(0, 7));
        imm = 16'($urandom());
        case (k)
            0:       return {6'h00, a, b, c, 5'($urandom_range(0, 31)), 6'h20};
            1:       return {6'h00, a, b, c, 5'd0, 6'h25};
            2:       return {6'h00, a, 15'h0, 6'h08};
            3:       return {6'h08, a, b, imm};
            4, 5:    return {6'h23, a, b, imm};
            6:       return {6'h2B, a, b, imm};
            7:       return {6'h04, a, b, imm};
            8:       return {6'h05, a, b, imm};
            9:       return {6'h02, 26'($urandom())};
            10:      return {6'h03, 26'($urandom())};
            11:      return {6'h0F, 5'd0, b, imm};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] cur;
        logic        rst, fl, we;
        logic [4:0]  wr;
        int          drain;

        reset = 1'b1; instruction_IF = 32'h2008_0005; pc_plus_4_IF = 0; flush_M = 0;
        reg_write_WB = 0; write_reg_WB = 0; write_data_WB = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_ifid_instr = 0; m_ifid_pc = 0; m_ex = zero_exp(); m_ex_is_load = 0; last_stall = 0;

        // Reset with addi $t0,$0,5 held, then two edges after release
        apply_stimulus(1'b1, 32'h2008_0005, 1'b0, 1'b0, 5'd0, 32'h0);
        apply_stimulus(1'b1, 32'h2008_0005, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        check_field("reset ctrl_EX", 32'(ctrl_EX), 32'h0);
        check_field("reset stall_IF", 32'(stall_IF), 32'h0);
        check_field("reset immediate_EX", immediate_EX, 32'h0);
        apply_instr(32'h2008_0005);
        apply_instr(32'h2008_0005);
        settle();
        check_field("addi alu_src/reg_write", 32'(ctrl_EX[1:0]), 32'h3);
        check_field("addi immediate_EX", immediate_EX, 32'd5);
        check_field("addi rt_EX", 32'(rt_EX), 32'd8);

        // Load-use: lw $t0 then add $t1,$t0,$t0
        apply_instr(32'h8C08_0000);
        apply_instr(32'h0108_4820);
        settle();
        check_field("load-use stall_IF", 32'(stall_IF), 32'h1);
        apply_instr(32'h0);
        settle();
        check_field("bubble ctrl_EX", 32'(ctrl_EX), 32'h0);
        check_field("stall one cycle", 32'(stall_IF), 32'h0);
        apply_instr(32'h0);
        settle();
        check_field("add rs_EX", 32'(rs_EX), 32'd8);
        check_field("add rt_EX", 32'(rt_EX), 32'd8);

        // WB write-through bypass into add $2,$9,$0
        apply_instr(32'h0120_1020);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        settle();
        check_field("bypass read_data_1_EX", read_data_1_EX, 32'hDEAD_BEEF);

        // $0 protection with or $3,$0,$0
        apply_stimulus(1'b0, 32'h0000_1825, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        settle();
        check_field("$0 read_data_1_EX", read_data_1_EX, 32'h0);
        check_field("$0 read_data_2_EX", read_data_2_EX, 32'h0);

        // Flush arriving together with a load-use stall
        apply_instr(32'h8C08_0000);
        apply_instr(32'h0108_4820);
        apply_stimulus(1'b0, 32'h2009_0007, 1'b1, 1'b0, 5'd0, 32'h0);
        settle();
        check_field("flush ctrl_EX", 32'(ctrl_EX), 32'h0);
        check_field("flush stall_IF", 32'(stall_IF), 32'h0);
        apply_instr(32'h2009_0007);
        apply_instr(32'h0);
        settle();
        check_field("post-flush immediate_EX", immediate_EX, 32'd7);
        check_field("post-flush rt_EX", 32'(rt_EX), 32'd9);
        apply_instr(32'h0);
        settle();
        check_field("post-flush no duplicate", 32'(ctrl_EX), 32'h0);

        // Reset asserted mid-stall
        apply_instr(32'h8C08_0000);
        apply_instr(32'h0108_4820);
        apply_stimulus(1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        check_field("reset mid-stall ctrl_EX", 32'(ctrl_EX), 32'h0);
        check_field("reset mid-stall stall_IF", 32'(stall_IF), 32'h0);

        // Negative immediate, then j 0x40
        apply_instr(32'h2008_8000);
        apply_instr(32'h0800_0040);
        settle();
        check_field("sign-extended immediate", immediate_EX, 32'hFFFF_8000);
        apply_instr(32'h0);
        settle();
        check_field("jump_field_EX", 32'(jump_field_EX), 32'h40);
        check_field("jump bits", 32'(ctrl_EX[13:12]), 32'h1);

        // Randomized traffic; IF repeats an instruction while the model reports a stall
        cur = gen_instr();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            we  = 1'($urandom_range(0, 1));
            wr  = 5'($urandom_range(0, 7));
            apply_stimulus(rst, cur, fl, we, wr, $urandom());
            if (!last_stall) cur = gen_instr();
        end

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge clk);
            #3;
            drain++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
